// File: rtl/duck_round_sequencer.sv
// duck_round_sequencer
//   Game-flow controller for the duck/dog/cursor datapath. Runs each round as
//   an intro followed by DUCKS_PER_ROUND duck flights, arbitrates shots per
//   duck, times the fly-away and dog show, and keeps score, high score and the
//   round pass / game over decision.
//
// Ports
//   Clk            in   system clock
//   Reset          in   asynchronous active-low reset
//   frame_tick     in   one-Clk pulse per video frame
//   start_req      in   level, start/restart (honoured only in IDLE/GAMEOVER)
//   trigger        in   raw mouse button level, rising edge = one shot
//   hit            in   cursor over live duck, sampled with the trigger edge
//   duck_launch    out  one-Clk pulse, animation loads a new duck
//   shoot_enable   out  shots accepted (FLIGHT only)
//   fly_away       out  duck escaping
//   duck_killed    out  duck falling
//   out_of_shots   out  shots_left reached 0 for the current duck
//   shots_left     out  remaining shots for current duck
//   duck_index     out  duck number within the round
//   hit_mask       out  bit i = duck i of this round was hit
//   RoundNumber    out  1-based round, saturates at 99
//   score          out  current score, saturating
//   highscore      out  best score since reset
//   gameoversignal out  game over display
//   dbg_state      out  current FSM state encoding (observability only)
//
// All outputs come straight from registers; each status flag is written on
// the same edge that moves the FSM into the state that owns it.
module duck_round_sequencer #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int INTRO_TICKS     = 120,
  parameter int FLIGHT_TICKS    = 300,
  parameter int RESULT_TICKS    = 60,
  parameter int PASS_BASE       = 6,
  parameter int SCORE_BASE      = 500
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        start_req,
  input  logic        trigger,
  input  logic        hit,
  output logic        duck_launch,
  output logic        shoot_enable,
  output logic        fly_away,
  output logic        duck_killed,
  output logic        out_of_shots,
  output logic [1:0]  shots_left,
  output logic [3:0]  duck_index,
  output logic [9:0]  hit_mask,
  output logic [7:0]  RoundNumber,
  output logic [20:0] score,
  output logic [20:0] highscore,
  output logic        gameoversignal,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INTRO     = 4'd1,
    S_LAUNCH    = 4'd2,
    S_FLIGHT    = 4'd3,
    S_HIT_FALL  = 4'd4,
    S_FLYAWAY   = 4'd5,
    S_NEXT      = 4'd6,
    S_ROUND_END = 4'd7,
    S_GAMEOVER  = 4'd8
  } state_t;

  state_t      r_state;
  logic [15:0] r_tick;
  logic        r_trig_q;
  logic        r_duck_launch;
  logic        r_shoot_enable;
  logic        r_fly_away;
  logic        r_duck_killed;
  logic        r_out_of_shots;
  logic [1:0]  r_shots_left;
  logic [3:0]  r_duck_index;
  logic [9:0]  r_hit_mask;
  logic [7:0]  r_round;
  logic [20:0] r_score;
  logic [20:0] r_highscore;
  logic        r_gameover;

  logic        w_shot;
  logic        w_intro_done;
  logic        w_flight_done;
  logic        w_result_done;
  logic [1:0]  w_shots_dec;
  logic [21:0] w_score_sum;
  logic [20:0] w_score_inc;
  logic [3:0]  w_hits;
  logic [8:0]  w_need_raw;
  logic [8:0]  w_need;
  logic        w_pass;

  // One registered sample of the button gives exactly one shot per press.
  assign w_shot = trigger & ~r_trig_q;

  // Each timed state ends on the frame tick that completes its N-th tick.
  assign w_intro_done  = frame_tick && (r_tick == 16'(INTRO_TICKS - 1));
  assign w_flight_done = frame_tick && (r_tick == 16'(FLIGHT_TICKS - 1));
  assign w_result_done = frame_tick && (r_tick == 16'(RESULT_TICKS - 1));

  assign w_shots_dec = r_shots_left - 2'd1;

  // Score add in 22 bits so the carry out selects the saturated value.
  assign w_score_sum = {1'b0, r_score} + 22'(SCORE_BASE);
  assign w_score_inc = w_score_sum[21] ? {21{1'b1}} : w_score_sum[20:0];

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < 10; i++) begin
      w_hits = w_hits + 4'(r_hit_mask[i]);
    end
  end

  // Pass threshold grows by one per round, capped at the ducks in a round.
  assign w_need_raw = 9'(PASS_BASE) + {1'b0, r_round} - 9'd1;
  assign w_need     = (w_need_raw > 9'(DUCKS_PER_ROUND)) ? 9'(DUCKS_PER_ROUND) : w_need_raw;
  assign w_pass     = ({5'd0, w_hits} >= w_need);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state        <= S_IDLE;
      r_tick         <= '0;
      r_trig_q       <= 1'b0;
      r_duck_launch  <= 1'b0;
      r_shoot_enable <= 1'b0;
      r_fly_away     <= 1'b0;
      r_duck_killed  <= 1'b0;
      r_out_of_shots <= 1'b0;
      r_shots_left   <= 2'(SHOTS_PER_DUCK);
      r_duck_index   <= '0;
      r_hit_mask     <= '0;
      r_round        <= 8'd1;
      r_score        <= '0;
      r_highscore    <= '0;
      r_gameover     <= 1'b0;
    end else begin
      r_trig_q <= trigger;
      if (frame_tick) r_tick <= r_tick + 16'd1;

      case (r_state)
        S_IDLE: begin
          if (start_req) begin
            r_state      <= S_INTRO;
            r_tick       <= '0;
            r_score      <= '0;
            r_hit_mask   <= '0;
            r_duck_index <= '0;
            r_round      <= 8'd1;
          end
        end

        S_INTRO: begin
          if (w_intro_done) begin
            r_state        <= S_LAUNCH;
            r_tick         <= '0;
            r_duck_launch  <= 1'b1;
            r_shots_left   <= 2'(SHOTS_PER_DUCK);
            r_out_of_shots <= 1'b0;
          end
        end

        S_LAUNCH: begin
          r_state        <= S_FLIGHT;
          r_tick         <= '0;
          r_duck_launch  <= 1'b0;
          r_shoot_enable <= 1'b1;
        end

        S_FLIGHT: begin
          // A shot in the timeout cycle is resolved first, so a hit still counts.
          if (w_shot) begin
            r_shots_left <= w_shots_dec;
            if (w_shots_dec == 2'd0) r_out_of_shots <= 1'b1;
            if (hit) begin
              r_state        <= S_HIT_FALL;
              r_tick         <= '0;
              r_shoot_enable <= 1'b0;
              r_duck_killed  <= 1'b1;
              r_hit_mask     <= r_hit_mask | (10'd1 << r_duck_index);
              r_score        <= w_score_inc;
            end else if ((w_shots_dec == 2'd0) || w_flight_done) begin
              r_state        <= S_FLYAWAY;
              r_tick         <= '0;
              r_shoot_enable <= 1'b0;
              r_fly_away     <= 1'b1;
            end
          end else if (w_flight_done) begin
            r_state        <= S_FLYAWAY;
            r_tick         <= '0;
            r_shoot_enable <= 1'b0;
            r_fly_away     <= 1'b1;
          end
        end

        S_HIT_FALL: begin
          if (w_result_done) begin
            r_state       <= S_NEXT;
            r_tick        <= '0;
            r_duck_killed <= 1'b0;
          end
        end

        S_FLYAWAY: begin
          if (w_result_done) begin
            r_state    <= S_NEXT;
            r_tick     <= '0;
            r_fly_away <= 1'b0;
          end
        end

        S_NEXT: begin
          r_tick <= '0;
          if (r_duck_index < 4'(DUCKS_PER_ROUND - 1)) begin
            r_state        <= S_LAUNCH;
            r_duck_index   <= r_duck_index + 4'd1;
            r_duck_launch  <= 1'b1;
            r_shots_left   <= 2'(SHOTS_PER_DUCK);
            r_out_of_shots <= 1'b0;
          end else begin
            r_state <= S_ROUND_END;
          end
        end

        S_ROUND_END: begin
          r_tick <= '0;
          if (w_pass) begin
            r_state      <= S_INTRO;
            r_round      <= (r_round >= 8'd99) ? 8'd99 : r_round + 8'd1;
            r_hit_mask   <= '0;
            r_duck_index <= '0;
          end else begin
            r_state    <= S_GAMEOVER;
            r_gameover <= 1'b1;
            if (r_score > r_highscore) r_highscore <= r_score;
          end
        end

        S_GAMEOVER: begin
          // Score stays on display here; IDLE clears it when the next game starts.
          if (start_req) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_gameover <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign duck_launch    = r_duck_launch;
  assign shoot_enable   = r_shoot_enable;
  assign fly_away       = r_fly_away;
  assign duck_killed    = r_duck_killed;
  assign out_of_shots   = r_out_of_shots;
  assign shots_left     = r_shots_left;
  assign duck_index     = r_duck_index;
  assign hit_mask       = r_hit_mask;
  assign RoundNumber    = r_round;
  assign score          = r_score;
  assign highscore      = r_highscore;
  assign gameoversignal = r_gameover;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_duck_round_sequencer.sv
module tb_duck_round_sequencer;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_INTRO    = 4'd1;
  localparam logic [3:0] ST_FLIGHT   = 4'd3;
  localparam logic [3:0] ST_FLYAWAY  = 4'd5;
  localparam logic [3:0] ST_GAMEOVER = 4'd8;

  // clock / reset / stimulus signals
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic frame_tick = 1'b0;
  logic start_req = 1'b0, trigger = 1'b0, hit = 1'b0;
  logic s_start_req = 1'b0, s_trigger = 1'b0, s_hit = 1'b0;

  logic        duck_launch, shoot_enable, fly_away, duck_killed, out_of_shots, gameoversignal;
  logic [1:0]  shots_left;
  logic [3:0]  duck_index, dbg_state;
  logic [9:0]  hit_mask;
  logic [7:0]  RoundNumber;
  logic [20:0] score, highscore;

  logic        s_duck_launch, s_shoot_enable, s_fly_away, s_duck_killed, s_out_of_shots, s_gameover;
  logic [1:0]  s_shots_left;
  logic [3:0]  s_duck_index, s_dbg_state;
  logic [9:0]  s_hit_mask;
  logic [7:0]  s_round;
  logic [20:0] s_score, s_highscore;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_total = 0;

  duck_round_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start_req(start_req),
    .trigger(trigger), .hit(hit), .duck_launch(duck_launch), .shoot_enable(shoot_enable),
    .fly_away(fly_away), .duck_killed(duck_killed), .out_of_shots(out_of_shots),
    .shots_left(shots_left), .duck_index(duck_index), .hit_mask(hit_mask),
    .RoundNumber(RoundNumber), .score(score), .highscore(highscore),
    .gameoversignal(gameoversignal), .dbg_state(dbg_state)
  );

  // Short-timed instance with a huge per-hit value to reach saturation quickly.
  duck_round_sequencer #(
    .INTRO_TICKS(4), .FLIGHT_TICKS(20), .RESULT_TICKS(2), .SCORE_BASE(1000000)
  ) dut_sat (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start_req(s_start_req),
    .trigger(s_trigger), .hit(s_hit), .duck_launch(s_duck_launch), .shoot_enable(s_shoot_enable),
    .fly_away(s_fly_away), .duck_killed(s_duck_killed), .out_of_shots(s_out_of_shots),
    .shots_left(s_shots_left), .duck_index(s_duck_index), .hit_mask(s_hit_mask),
    .RoundNumber(s_round), .score(s_score), .highscore(s_highscore),
    .gameoversignal(s_gameover), .dbg_state(s_dbg_state)
  );

  // clock and frame tick: frame_tick is high on every other rising edge
  always #5 Clk = ~Clk;

  initial begin
    forever begin
      @(posedge Clk);
      #2;
      frame_tick = ~frame_tick;
    end
  end

  always @(posedge Clk) if (frame_tick) tick_total <= tick_total + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic wait_launch(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (duck_launch) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fire(input logic h, input int hold);
    trigger = 1'b1;
    hit = h;
    repeat (hold) @(negedge Clk);
    trigger = 1'b0;
    hit = 1'b0;
    @(negedge Clk);
  endtask

  task automatic play_duck(input logic h, output bit ok);
    wait_launch(2000, ok);
    if (ok) begin
      @(negedge Clk);
      if (h) fire(1'b1, 1);
      else begin
        fire(1'b0, 1);
        fire(1'b0, 1);
        fire(1'b0, 1);
      end
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    tests_run++; if (RoundNumber !== 8'd1) begin tests_failed++; $display("FAIL reset_round: got %0d expected 1", RoundNumber); end
    tests_run++; if (shots_left !== 2'd3) begin tests_failed++; $display("FAIL reset_shots: got %0d expected 3", shots_left); end
    tests_run++; if ({score, highscore} !== 42'd0) begin tests_failed++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", score, highscore); end
    tests_run++; if ({duck_launch, shoot_enable, fly_away, duck_killed, out_of_shots, gameoversignal, hit_mask, duck_index} !== 20'd0) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected all zero", {duck_launch, shoot_enable, fly_away, duck_killed, out_of_shots, gameoversignal, hit_mask, duck_index}); end
  endtask

  task automatic test_intro_launch();
    bit ok;
    int s;
    start_req = 1'b1;
    s = tick_total + (frame_tick ? 1 : 0);
    @(negedge Clk);
    start_req = 1'b0;
    tests_run++; if (dbg_state !== ST_INTRO) begin tests_failed++; $display("FAIL intro_state: got %0d expected %0d", dbg_state, ST_INTRO); end
    wait_launch(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL intro_launch: got no launch expected launch"); end
    tests_run++; if (tick_total - s !== 120) begin tests_failed++; $display("FAIL intro_ticks: got %0d expected 120", tick_total - s); end
    @(negedge Clk);
    tests_run++; if (duck_launch !== 1'b0) begin tests_failed++; $display("FAIL launch_pulse_width: got %0d expected 0", duck_launch); end
    tests_run++; if (shoot_enable !== 1'b1) begin tests_failed++; $display("FAIL launch_shoot_enable: got %0d expected 1", shoot_enable); end
    tests_run++; if (shots_left !== 2'd3) begin tests_failed++; $display("FAIL launch_shots: got %0d expected 3", shots_left); end
  endtask

  task automatic test_misses();
    fire(1'b0, 3);  // button held for 3 clocks: still one shot
    tests_run++; if (shots_left !== 2'd2) begin tests_failed++; $display("FAIL miss1_shots: got %0d expected 2", shots_left); end
    fire(1'b0, 1);
    tests_run++; if (shots_left !== 2'd1) begin tests_failed++; $display("FAIL miss2_shots: got %0d expected 1", shots_left); end
    tests_run++; if (shoot_enable !== 1'b1) begin tests_failed++; $display("FAIL miss2_enable: got %0d expected 1", shoot_enable); end
    fire(1'b0, 1);
    tests_run++; if (shots_left !== 2'd0) begin tests_failed++; $display("FAIL miss3_shots: got %0d expected 0", shots_left); end
    tests_run++; if ({out_of_shots, fly_away, shoot_enable} !== 3'b110) begin tests_failed++; $display("FAIL miss3_flags: got %b expected 110", {out_of_shots, fly_away, shoot_enable}); end
    fire(1'b1, 1);  // fourth press outside FLIGHT
    tests_run++; if (shots_left !== 2'd0) begin tests_failed++; $display("FAIL miss4_shots: got %0d expected 0", shots_left); end
    tests_run++; if (dbg_state !== ST_FLYAWAY) begin tests_failed++; $display("FAIL miss4_state: got %0d expected %0d", dbg_state, ST_FLYAWAY); end
    tests_run++; if ({score, hit_mask} !== 31'd0) begin tests_failed++; $display("FAIL miss4_score: got %0d/%b expected 0/0", score, hit_mask); end
  endtask

  task automatic test_timeout();
    bit ok;
    int s;
    wait_launch(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL timeout_launch: got no launch expected launch"); end
    tests_run++; if (duck_index !== 4'd1) begin tests_failed++; $display("FAIL timeout_index: got %0d expected 1", duck_index); end
    tests_run++; if ({out_of_shots, shots_left} !== 3'b011) begin tests_failed++; $display("FAIL timeout_relaunch: got %b expected 011", {out_of_shots, shots_left}); end
    @(negedge Clk);
    s = tick_total;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (fly_away) begin ok = 1'b1; break; end
    end
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL timeout_flyaway: got no fly_away expected fly_away"); end
    tests_run++; if (tick_total - s !== 300) begin tests_failed++; $display("FAIL timeout_ticks: got %0d expected 300", tick_total - s); end
    tests_run++; if ({out_of_shots, shots_left} !== 3'b011) begin tests_failed++; $display("FAIL timeout_shots: got %b expected 011", {out_of_shots, shots_left}); end
  endtask

  task automatic test_timeout_hit();
    bit ok;
    bit armed;
    int s;
    wait_launch(1000, ok);
    @(negedge Clk);
    s = tick_total;
    armed = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ((tick_total - s == 299) && frame_tick) begin
        armed = 1'b1;
        trigger = 1'b1;
        hit = 1'b1;
        @(negedge Clk);
        trigger = 1'b0;
        hit = 1'b0;
        break;
      end
      @(negedge Clk);
    end
    tests_run++; if (!(ok && armed)) begin tests_failed++; $display("FAIL tohit_setup: got %0d%0d expected 11", ok, armed); end
    tests_run++; if ({duck_killed, fly_away} !== 2'b10) begin tests_failed++; $display("FAIL tohit_flags: got %b expected 10", {duck_killed, fly_away}); end
    tests_run++; if (score !== 21'd500) begin tests_failed++; $display("FAIL tohit_score: got %0d expected 500", score); end
    tests_run++; if (hit_mask !== 10'b0000000100) begin tests_failed++; $display("FAIL tohit_mask: got %b expected 0000000100", hit_mask); end
    tests_run++; if (shots_left !== 2'd2) begin tests_failed++; $display("FAIL tohit_shots: got %0d expected 2", shots_left); end
  endtask

  task automatic test_round_pass();
    bit ok;
    bit all_ok = 1'b1;
    for (int d = 3; d < 10; d++) begin
      play_duck(d <= 7, ok);
      all_ok &= ok;
    end
    tests_run++; if (!all_ok) begin tests_failed++; $display("FAIL r1_launches: got missing launch expected 7 launches"); end
    tests_run++; if (hit_mask !== 10'h0FC) begin tests_failed++; $display("FAIL r1_mask: got %h expected 0fc", hit_mask); end
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      if (RoundNumber != 8'd1 || gameoversignal) break;
    end
    tests_run++; if (RoundNumber !== 8'd2) begin tests_failed++; $display("FAIL r1_round: got %0d expected 2", RoundNumber); end
    tests_run++; if (score !== 21'd3000) begin tests_failed++; $display("FAIL r1_score: got %0d expected 3000", score); end
    tests_run++; if ({dbg_state, hit_mask, duck_index, gameoversignal} !== {ST_INTRO, 15'd0}) begin
      tests_failed++; $display("FAIL r1_next_round: got %0d/%h/%0d/%0d expected 1/0/0/0", dbg_state, hit_mask, duck_index, gameoversignal); end
  endtask

  task automatic test_gameover();
    bit ok;
    bit all_ok = 1'b1;
    for (int d = 0; d < 10; d++) begin
      play_duck(d < 6, ok);
      all_ok &= ok;
    end
    tests_run++; if (!all_ok) begin tests_failed++; $display("FAIL r2_launches: got missing launch expected 10 launches"); end
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      if (gameoversignal || RoundNumber != 8'd2) break;
    end
    tests_run++; if ({gameoversignal, dbg_state} !== {1'b1, ST_GAMEOVER}) begin tests_failed++; $display("FAIL r2_gameover: got %0d/%0d expected 1/8", gameoversignal, dbg_state); end
    tests_run++; if (score !== 21'd6000) begin tests_failed++; $display("FAIL r2_score: got %0d expected 6000", score); end
    tests_run++; if (highscore !== 21'd6000) begin tests_failed++; $display("FAIL r2_highscore: got %0d expected 6000", highscore); end
    tests_run++; if ({RoundNumber, hit_mask} !== {8'd2, 10'h03F}) begin tests_failed++; $display("FAIL r2_round_mask: got %0d/%h expected 2/03f", RoundNumber, hit_mask); end
  endtask

  task automatic test_restart();
    start_req = 1'b1;
    @(negedge Clk);
    tests_run++; if ({dbg_state, gameoversignal} !== {ST_IDLE, 1'b0}) begin tests_failed++; $display("FAIL restart_idle: got %0d/%0d expected 0/0", dbg_state, gameoversignal); end
    tests_run++; if (score !== 21'd6000) begin tests_failed++; $display("FAIL restart_score_held: got %0d expected 6000", score); end
    @(negedge Clk);
    start_req = 1'b0;
    tests_run++; if (dbg_state !== ST_INTRO) begin tests_failed++; $display("FAIL restart_intro: got %0d expected %0d", dbg_state, ST_INTRO); end
    tests_run++; if ({score, RoundNumber} !== {21'd0, 8'd1}) begin tests_failed++; $display("FAIL restart_clear: got %0d/%0d expected 0/1", score, RoundNumber); end
    tests_run++; if (highscore !== 21'd6000) begin tests_failed++; $display("FAIL restart_highscore: got %0d expected 6000", highscore); end
  endtask

  task automatic test_reset_mid_flight();
    bit ok;
    play_duck(1'b1, ok);
    wait_launch(1000, ok);
    @(negedge Clk);
    tests_run++; if ({dbg_state, score} !== {ST_FLIGHT, 21'd500}) begin tests_failed++; $display("FAIL midrst_setup: got %0d/%0d expected 3/500", dbg_state, score); end
    Reset = 1'b0;
    @(negedge Clk);
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL midrst_state: got %0d expected 0", dbg_state); end
    tests_run++; if ({score, highscore} !== 42'd0) begin tests_failed++; $display("FAIL midrst_scores: got %0d/%0d expected 0/0", score, highscore); end
    tests_run++; if ({shots_left, RoundNumber, shoot_enable} !== {2'd3, 8'd1, 1'b0}) begin
      tests_failed++; $display("FAIL midrst_misc: got %0d/%0d/%0d expected 3/1/0", shots_left, RoundNumber, shoot_enable); end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_saturation();
    int unsigned exp_sat[3] = '{1000000, 2000000, 2097151};
    bit ok;
    s_start_req = 1'b1;
    @(negedge Clk);
    s_start_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge Clk);
        if (s_duck_launch) begin ok = 1'b1; break; end
      end
      @(negedge Clk);
      s_trigger = 1'b1;
      s_hit = 1'b1;
      @(negedge Clk);
      s_trigger = 1'b0;
      s_hit = 1'b0;
      tests_run++; if (!ok || s_score !== 21'(exp_sat[k])) begin tests_failed++; $display("FAIL sat_score%0d: got %0d expected %0d", k, s_score, exp_sat[k]); end
    end
    tests_run++; if ({s_hit_mask, s_highscore} !== {10'h007, 21'd0}) begin tests_failed++; $display("FAIL sat_mask_hs: got %h/%0d expected 007/0", s_hit_mask, s_highscore); end
  endtask

  initial begin
    test_reset();
    test_intro_launch();
    test_misses();
    test_timeout();
    test_timeout_hit();
    test_round_pass();
    test_gameover();
    test_restart();
    test_reset_mid_flight();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
